// File: rtl/mac24_core.sv
// ---------------------------------------------------------------------------
// mac24_core
//
// Purpose:
//   Multiply-accumulate core for 24-bit signed samples. Two 16 x 24 RAMs
//   (coefficients and data) have synchronous writes and combinational reads.
//   The two words read in a cycle are multiplied into a registered 47-bit
//   product on the next edge. That product can then be added into a 50-bit
//   signed accumulator on the edge after.
//
// Ports:
//   clock          in   1   single clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   coeff_wr       in   1   coefficient RAM write strobe
//   coeff_wr_addr  in   4   coefficient RAM write address
//   coeff_wr_data  in  24   coefficient RAM write data
//   coeff_rd_addr  in   4   coefficient RAM read address
//   data_wr        in   1   data RAM write strobe
//   data_wr_addr   in   4   data RAM write address
//   data_wr_data   in  24   data RAM write data
//   data_rd_addr   in   4   data RAM read address
//   mult_en        in   1   load product from the current RAM read words
//   acc_clear      in   1   clear accumulator (wins over acc_en)
//   acc_en         in   1   add product into accumulator
//   coeff          out 24   coefficient RAM read data
//   data           out 24   data RAM read data
//   product        out 47   registered signed product
//   product_valid  out  1   mult_en delayed by one cycle
//   accum          out 50   registered signed accumulator
//   accum_valid    out  1   high for the cycle after an accumulate
//
// Configuration:
//   MAC24_ACC_SAT_EN  defined   -> accumulator saturates on overflow
//                     undefined -> accumulator wraps modulo 2^50
// ---------------------------------------------------------------------------
module mac24_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        coeff_wr,
  input  logic [3:0]  coeff_wr_addr,
  input  logic [23:0] coeff_wr_data,
  input  logic [3:0]  coeff_rd_addr,
  input  logic        data_wr,
  input  logic [3:0]  data_wr_addr,
  input  logic [23:0] data_wr_data,
  input  logic [3:0]  data_rd_addr,
  input  logic        mult_en,
  input  logic        acc_clear,
  input  logic        acc_en,
  output logic [23:0] coeff,
  output logic [23:0] data,
  output logic [46:0] product,
  output logic        product_valid,
  output logic [49:0] accum,
  output logic        accum_valid
);

  logic [23:0] coeff_mem [16];
  logic [23:0] data_mem  [16];

  logic [46:0] mult_trunc;
  logic        mult_corner;
  logic [46:0] product_next;
  logic [49:0] accum_sum;

  // RAM storage is deliberately left out of reset. Reads are combinational,
  // so a same-cycle write to the read address only shows up after the edge.
  always_ff @(posedge clock) begin
    if (coeff_wr) begin
      coeff_mem[coeff_wr_addr] <= coeff_wr_data;
    end
    if (data_wr) begin
      data_mem[data_wr_addr] <= data_wr_data;
    end
  end

  assign coeff = coeff_mem[coeff_rd_addr];
  assign data  = data_mem[data_rd_addr];

  // Operands are sign-extended to 47 bits, so the multiply gives the product
  // already truncated to bits [46:0]. The only pair whose true product does
  // not fit is -2^23 x -2^23 = +2^46. That case is clamped to +2^46-1 rather
  // than left to wrap negative.
  assign mult_trunc   = $signed({{23{data[23]}}, data}) * $signed({{23{coeff[23]}}, coeff});
  assign mult_corner  = (data == 24'h800000) && (coeff == 24'h800000);
  assign product_next = mult_corner ? 47'h3FFF_FFFF_FFFF : mult_trunc;

`ifdef MAC24_ACC_SAT_EN
  // The sum is formed one bit wider. Signed overflow shows up as a mismatch
  // between the two top bits, and bit 50 gives the true sign of the result.
  logic [50:0] accum_wide;

  assign accum_wide = {accum[49], accum} + {{4{product[46]}}, product};

  always_comb begin
    accum_sum = accum_wide[49:0];
    if (accum_wide[50] != accum_wide[49]) begin
      accum_sum = accum_wide[50] ? 50'h2_0000_0000_0000 : 50'h1_FFFF_FFFF_FFFF;
    end
  end
`else
  // The plain 50-bit add wraps modulo 2^50.
  assign accum_sum = accum + {{3{product[46]}}, product};
`endif

  // Multiplier stage: the product holds whenever mult_en is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      product_valid <= mult_en;
      if (mult_en) begin
        product <= product_next;
      end
    end
  end

  // Accumulator stage: clear beats enable, and accum_valid flags only a real
  // accumulate, not a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accum       <= '0;
      accum_valid <= 1'b0;
    end else begin
      accum_valid <= acc_en & ~acc_clear;
      if (acc_clear) begin
        accum <= '0;
      end else if (acc_en) begin
        accum <= accum_sum;
      end
    end
  end

endmodule

// File: tb/tb_mac24_core.sv
// ---------------------------------------------------------------------------
// tb_mac24_core
//
// Directed testbench for mac24_core. It loads both RAMs, then walks through
// multiply, accumulate, corner-case, asynchronous reset and overflow
// scenarios. Every expected value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_mac24_core;

  logic        clock;
  logic        reset_n;
  logic        coeff_wr;
  logic [3:0]  coeff_wr_addr;
  logic [23:0] coeff_wr_data;
  logic [3:0]  coeff_rd_addr;
  logic        data_wr;
  logic [3:0]  data_wr_addr;
  logic [23:0] data_wr_data;
  logic [3:0]  data_rd_addr;
  logic        mult_en;
  logic        acc_clear;
  logic        acc_en;
  logic [23:0] coeff;
  logic [23:0] data;
  logic [46:0] product;
  logic        product_valid;
  logic [49:0] accum;
  logic        accum_valid;

  int errors = 0;
  int checks = 0;

  mac24_core dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .coeff_wr      (coeff_wr),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .coeff_rd_addr (coeff_rd_addr),
    .data_wr       (data_wr),
    .data_wr_addr  (data_wr_addr),
    .data_wr_data  (data_wr_data),
    .data_rd_addr  (data_rd_addr),
    .mult_en       (mult_en),
    .acc_clear     (acc_clear),
    .acc_en        (acc_en),
    .coeff         (coeff),
    .data          (data),
    .product       (product),
    .product_valid (product_valid),
    .accum         (accum),
    .accum_valid   (accum_valid)
  );

  // The clock period is 10 time units, with rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison. The values are widened to 50 bits so a single task
  // covers every output.
  task automatic checkOutput(input string tag, input logic [49:0] observed,
                             input logic [49:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits for the next rising edge, then settles 1 unit past it. Both
  // sampling and the next input changes happen at that point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sets the read addresses and pipeline controls, then advances one edge.
  task automatic applyStimulus(input logic [3:0] rd_addr, input logic m_en,
                               input logic a_clr, input logic a_en);
    coeff_rd_addr = rd_addr;
    data_rd_addr  = rd_addr;
    mult_en       = m_en;
    acc_clear     = a_clr;
    acc_en        = a_en;
    tick();
  endtask

  // Writes the same address in both RAMs during one edge.
  task automatic writeRams(input logic [3:0] addr, input logic [23:0] cval,
                           input logic [23:0] dval);
    coeff_wr      = 1'b1;
    coeff_wr_addr = addr;
    coeff_wr_data = cval;
    data_wr       = 1'b1;
    data_wr_addr  = addr;
    data_wr_data  = dval;
    tick();
    coeff_wr = 1'b0;
    data_wr  = 1'b0;
  endtask

  // The whole run is one directed sequence.
  initial begin
    reset_n       = 1'b0;
    coeff_wr      = 1'b0;
    coeff_wr_addr = '0;
    coeff_wr_data = '0;
    coeff_rd_addr = '0;
    data_wr       = 1'b0;
    data_wr_addr  = '0;
    data_wr_data  = '0;
    data_rd_addr  = '0;
    mult_en       = 1'b0;
    acc_clear     = 1'b0;
    acc_en        = 1'b0;

    #2;
    checkOutput("reset_product", {3'b0, product}, 50'h0);
    checkOutput("reset_product_valid", {49'b0, product_valid}, 50'h0);
    checkOutput("reset_accum", accum, 50'h0);
    checkOutput("reset_accum_valid", {49'b0, accum_valid}, 50'h0);

    #10;
    reset_n = 1'b1;
    tick();

    writeRams(4'd3, 24'h000100, 24'h000200);
    writeRams(4'd4, 24'h800000, 24'h800000);
    writeRams(4'd5, 24'h000001, 24'h000111);
    writeRams(4'd6, 24'h000005, 24'hFFFFFF);

    // Scenario 1: 0x200 x 0x100 gives 0x20000 one cycle after the read.
    coeff_rd_addr = 4'd3;
    data_rd_addr  = 4'd3;
    #1;
    checkOutput("s1_coeff_read", {26'b0, coeff}, 50'h100);
    checkOutput("s1_data_read", {26'b0, data}, 50'h200);
    applyStimulus(4'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("s1_product", {3'b0, product}, 50'h20000);
    checkOutput("s1_product_valid", {49'b0, product_valid}, 50'h1);
    applyStimulus(4'd6, 1'b0, 1'b0, 1'b0);
    checkOutput("s1_product_hold", {3'b0, product}, 50'h20000);
    checkOutput("s1_product_valid_low", {49'b0, product_valid}, 50'h0);

    // Scenario 2: clear, then three accumulates of 0x20000.
    applyStimulus(4'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("s2_clear_accum", accum, 50'h0);
    checkOutput("s2_clear_valid", {49'b0, accum_valid}, 50'h0);
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_acc1", accum, 50'h20000);
    checkOutput("s2_acc1_valid", {49'b0, accum_valid}, 50'h1);
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_acc2", accum, 50'h40000);
    checkOutput("s2_acc2_valid", {49'b0, accum_valid}, 50'h1);
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_acc3", accum, 50'h60000);
    checkOutput("s2_acc3_valid", {49'b0, accum_valid}, 50'h1);
    applyStimulus(4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("s2_hold", accum, 50'h60000);
    checkOutput("s2_hold_valid", {49'b0, accum_valid}, 50'h0);
    applyStimulus(4'd3, 1'b0, 1'b1, 1'b1);
    checkOutput("s2_clear_priority", accum, 50'h0);
    checkOutput("s2_clear_priority_valid", {49'b0, accum_valid}, 50'h0);

    // Scenario 3: -2^23 x -2^23 clamps to +2^46-1.
    applyStimulus(4'd4, 1'b1, 1'b0, 1'b0);
    checkOutput("s3_corner_product", {3'b0, product}, 50'h3FFF_FFFF_FFFF);

    // Scenario 4: -1 x 5. The read happens in cycle N with a clear, and the
    // accumulate lands in cycle N+2.
    applyStimulus(4'd6, 1'b1, 1'b1, 1'b0);
    checkOutput("s4_product", {3'b0, product}, 50'h7FFF_FFFF_FFFB);
    applyStimulus(4'd6, 1'b1, 1'b0, 1'b1);
    checkOutput("s4_accum", accum, 50'h3_FFFF_FFFF_FFFB);
    checkOutput("s4_accum_valid", {49'b0, accum_valid}, 50'h1);

    // Scenario 5: an asynchronous reset mid-cycle clears the pipeline
    // before the next edge.
    checkOutput("s5_pre_product_valid", {49'b0, product_valid}, 50'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_reset_accum", accum, 50'h0);
    checkOutput("s5_reset_product", {3'b0, product}, 50'h0);
    checkOutput("s5_reset_product_valid", {49'b0, product_valid}, 50'h0);
    checkOutput("s5_reset_accum_valid", {49'b0, accum_valid}, 50'h0);
    reset_n = 1'b1;
    mult_en = 1'b0;
    acc_en  = 1'b0;
    tick();

    // A same-cycle write and read of address 5 returns the old word. The
    // product therefore captures old x 1.
    data_wr       = 1'b1;
    data_wr_addr  = 4'd5;
    data_wr_data  = 24'h000222;
    coeff_rd_addr = 4'd5;
    data_rd_addr  = 4'd5;
    mult_en       = 1'b1;
    #1;
    checkOutput("s5_same_cycle_old", {26'b0, data}, 50'h111);
    tick();
    data_wr = 1'b0;
    checkOutput("s5_product_old_word", {3'b0, product}, 50'h111);
    checkOutput("s5_new_word_after_edge", {26'b0, data}, 50'h222);

    // Scenario 6: nine accumulates of +2^46-1 overflow the 50-bit range.
    applyStimulus(4'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'd4, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("s6_acc8", accum, 50'h1_FFFF_FFFF_FFF8);
    applyStimulus(4'd4, 1'b1, 1'b0, 1'b1);
`ifdef MAC24_ACC_SAT_EN
    checkOutput("s6_acc9_saturated", accum, 50'h1_FFFF_FFFF_FFFF);
`else
    checkOutput("s6_acc9_wrapped", accum, 50'h2_3FFF_FFFF_FFF7);
`endif
    applyStimulus(4'd4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac24_core.md
MAC24_CORE -- requirements
Module: mac24_core

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 coeff_wr  in  1  write strobe for the coefficient RAM.
REQ-005 coeff_wr_addr  in  4  coefficient RAM write address.
REQ-006 coeff_wr_data  in  24  coefficient RAM write data.
REQ-007 coeff_rd_addr  in  4  coefficient RAM read address.
REQ-008 data_wr  in  1  write strobe for the data RAM.
REQ-009 data_wr_addr  in  4  data RAM write address.
REQ-010 data_wr_data  in  24  data RAM write data.
REQ-011 data_rd_addr  in  4  data RAM read address.
REQ-012 mult_en  in  1  multiplier enable.
REQ-013 acc_clear  in  1  accumulator clear.
REQ-014 acc_en  in  1  accumulator enable.
REQ-015 coeff  out  24  coefficient RAM read data.
REQ-016 data  out  24  data RAM read data.
REQ-017 product  out  47  registered signed product.
REQ-018 product_valid  out  1  mult_en delayed by one cycle.
REQ-019 accum  out  50  registered signed accumulator.
REQ-020 accum_valid  out  1  set for the cycle after an accumulate.

Function
REQ-021 Each RAM SHALL be 16 x 24 bits, with a synchronous write on the clock edge when its strobe is 1 and a combinational read.
REQ-022 A read of an address written in the same cycle SHALL return the old word; the new word SHALL appear on the read port after that edge.
REQ-023 When mult_en=1, the edge SHALL load product with signed(data) x signed(coeff), truncated to bits [46:0]; when mult_en=0, product SHALL hold.
REQ-024 Multiplier corner case: 0x800000 x 0x800000 SHALL load the saturated value 47'h3FFF_FFFF_FFFF (+2^46-1).
REQ-025 product_valid SHALL load mult_en on every edge.
REQ-026 acc_clear=1 SHALL load accum with 0 on the next edge and SHALL take priority over acc_en.
REQ-027 acc_clear=0 with acc_en=1 SHALL load accum with accum + sign-extended(product) (47 to 50 bits); acc_en=0 SHALL hold accum.
REQ-028 accum_valid SHALL load (acc_en & ~acc_clear) on every edge.
REQ-029 Pipeline latency: read addresses in cycle N give product in cycle N+1 and the accumulated result in cycle N+2.

Reset
REQ-030 reset_n=0 SHALL immediately force product=0, product_valid=0, accum=0 and accum_valid=0, including mid-accumulation.
REQ-031 RAM contents SHALL NOT be reset; contents are undefined until written.

Configuration
REQ-032 Macro MAC24_ACC_SAT_EN defined: accumulation SHALL saturate to +2^49-1 or -2^49 on overflow.
REQ-033 Macro MAC24_ACC_SAT_EN undefined: accumulation SHALL wrap modulo 2^50.

Verification
REQ-034 Scenario 1: write coeff[3]=0x000100 and data[3]=0x000200; read address 3 with mult_en=1 -> next cycle product=0x20000 and product_valid=1.
REQ-035 Scenario 2: acc_clear for 1 cycle, then acc_en for 3 cycles with product=0x20000 -> accum=0x60000; accum_valid=1 on each of those 3 cycles.
REQ-036 Scenario 3: data=coeff=0x800000 -> product=47'h3FFF_FFFF_FFFF.
REQ-037 Scenario 4: data=0xFFFFFF, coeff=0x000005 -> product=47'h7FFF_FFFF_FFFB; after clear plus one accumulate, accum=50'h3_FFFF_FFFF_FFFB.
REQ-038 Scenario 5: with accum nonzero, pulse reset_n low between clock edges -> accum=0 and both valids=0 before the next edge; same-cycle write/read of one address returns the old data.
REQ-039 Scenario 6: accumulate +2^46-1 nine times -> with the macro, accum=2^49-1; without the macro, accum wraps to a negative value.
